ram_sdp_fifo: RTL and testbench
===============================

Name: ram_sdp_fifo

Overview:
- Single-clock first-word-fall-through (FWFT) FIFO built on distributed simple-dual-port RAM.
- Generalises the fixed 32-entry, 6-bit SDP RAM to parametrised width and depth.
- Adds valid/ready handshakes, occupancy count, almost-full flag, sticky overflow and synchronous flush.
- Used as a small elastic buffer between streaming stages in the FPGA datapath.

Parameters:
WIDTH, 6, data word width in bits; any value >= 1.
DEPTH_LOG2, 5, log2 of the entry count; valid range 5..8, giving DEPTH = 32..256 entries.
AFULL_THRESH, 28, almost-full assert level in entries; valid range 1..DEPTH.

Ports:
clk  in  1  single clock for all logic.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous clear of the FIFO contents.
in_valid  in  1  write request.
in_ready  out  1  FIFO can accept a word this cycle.
in_data  in  WIDTH  write word.
out_valid  out  1  out_data holds the oldest stored word.
out_ready  in  1  consumer accepts out_data this cycle.
out_data  out  WIDTH  oldest stored word; combinational read of RAM at the read pointer.
used  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
afull  out  1  asserted when used >= AFULL_THRESH.
overflow  out  1  sticky flag: a write was attempted while full.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Read and write pointers = 0, used = 0, out_valid = 0, afull = 0, overflow = 0, in_ready = 1.
  - RAM contents are not reset; out_data is don't-care while out_valid = 0.
- Pointers:
  - Write and read pointers are DEPTH_LOG2+1 bits wide and wrap naturally modulo 2*DEPTH.
  - RAM address = pointer[DEPTH_LOG2-1:0].
  - used = wptr - rptr, registered.
- Full/empty status:
  - full = (used == DEPTH); empty = (used == 0).
  - in_ready = !full, combinational from the used register.
  - out_valid = !empty.
- Push: when in_valid && in_ready at a clk edge, in_data is written at wptr and wptr increments.
- Pop: when out_valid && out_ready at a clk edge, rptr increments.
  - out_ready while empty has no effect.
- Latency: a word pushed into an empty FIFO at edge N appears with out_valid = 1 in the cycle following edge N.
- Simultaneous push and pop:
  - Both occur; used is unchanged.
  - When full, in_ready = 0, so a push is refused even if a pop happens in the same cycle (no full pass-through).
  - When empty, only the push occurs.
- Overflow:
  - in_valid && !in_ready at an edge sets overflow; the word is dropped and state is otherwise unchanged.
  - overflow stays set until flush or reset.
- Flush:
  - At the next edge: wptr = rptr = 0, used = 0, overflow = 0.
  - Overrides any push or pop in the same cycle; the pushed word is discarded.
- afull:
  - Registered together with used: afull = (next used >= AFULL_THRESH).
  - Updates in the same cycle that used changes.
- Storage:
  - Organised as 2^(DEPTH_LOG2-5) banks of 32-entry SDP RAM, each ceil(WIDTH/6)*6 bits wide; unused high bits are tied to 0.
  - Writes go only to the bank selected by wptr[DEPTH_LOG2-1:5].
  - Read output is muxed by rptr[DEPTH_LOG2-1:5].
- Write-then-read of the same address in one cycle cannot occur, because a slot is only read once it is non-empty, i.e. already written.

Test Plan:
1. Reset, then push 0x01..0x05 on consecutive cycles with out_ready = 0 -> used = 5, out_valid = 1, out_data = 0x01; then out_ready = 1 for 5 cycles -> outputs 0x01..0x05 in order, used = 0, out_valid = 0.
2. DEPTH_LOG2 = 5, AFULL_THRESH = 28: push 32 words -> afull rises on the edge where used becomes 28, in_ready = 0 at used = 32; a 33rd push attempt -> overflow = 1, used stays 32, contents intact.
3. Continuous push and pop for 100 words with an incrementing pattern -> used stays at 1 after the first word, pointers wrap past 64, and every word out equals its word in.
4. DEPTH_LOG2 = 7, WIDTH = 16: fill to 128 with the pattern i*0x0101, drain fully -> data is correct across all 4 banks and used returns to 0.
5. Full FIFO with overflow = 1: assert flush together with in_valid and out_ready -> next cycle used = 0, overflow = 0, out_valid = 0, and the pushed word is absent.
6. Deassert rst_n asynchronously mid-burst with used = 10 -> outputs reach their reset values immediately without a clock edge, and normal push resumes after release.

Source files
------------

// File: rtl/ram_sdp_fifo.sv
// First-word-fall-through FIFO on banked 32-entry distributed SDP RAM.
// Handshake in/out, registered occupancy and almost-full, sticky overflow, synchronous flush.
module ram_sdp_fifo #(
  parameter int WIDTH        = 6,
  parameter int DEPTH_LOG2   = 5,
  parameter int AFULL_THRESH = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [DEPTH_LOG2:0]   used,
  output logic                  afull,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int NBANK = 1 << (DEPTH_LOG2 - 5);
  localparam int BW    = ((WIDTH + 5) / 6) * 6;

  logic [PW-1:0]         wptr, rptr;
  logic [PW-1:0]         wptr_nxt, rptr_nxt, used_nxt;
  logic [DEPTH_LOG2-1:0] waddr, raddr;
  logic                  full, empty, push, pop;
  logic [BW-1:0]         wword;
  logic [WIDTH-1:0]      bank_q [NBANK];

  assign full      = (used == PW'(DEPTH));
  assign empty     = (used == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign pop       = out_ready && !empty;
  assign waddr     = wptr[DEPTH_LOG2-1:0];
  assign raddr     = rptr[DEPTH_LOG2-1:0];

  // Flush wins over any push or pop presented in the same cycle.
  always_comb begin
    wptr_nxt = wptr;
    rptr_nxt = rptr;
    if (flush) begin
      wptr_nxt = '0;
      rptr_nxt = '0;
    end else begin
      if (push) wptr_nxt = wptr + PW'(1);
      if (pop)  rptr_nxt = rptr + PW'(1);
    end
  end

  assign used_nxt = wptr_nxt - rptr_nxt;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      used     <= '0;
      afull    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wptr  <= wptr_nxt;
      rptr  <= rptr_nxt;
      used  <= used_nxt;
      afull <= (used_nxt >= PW'(AFULL_THRESH));
      if (flush)                overflow <= 1'b0;
      else if (in_valid && full) overflow <= 1'b1;
    end
  end

  // Zero-extend the write word to the 6-bit-granular bank width.
  always_comb begin
    wword              = '0;
    wword[WIDTH-1:0]   = in_data;
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    logic [BW-1:0] ram [32];
    logic          wsel;

    assign wsel = ((waddr >> 5) == DEPTH_LOG2'(b));

    // NOTE: RAM contents have no reset so the array maps onto distributed LUT RAM.
    always_ff @(posedge clk) begin
      if (push && !flush && wsel) ram[waddr[4:0]] <= wword;
    end

    assign bank_q[b] = ram[raddr[4:0]][WIDTH-1:0];
  end

  always_comb begin
    out_data = bank_q[0];
    for (int b = 1; b < NBANK; b++) begin
      if ((raddr >> 5) == DEPTH_LOG2'(b)) out_data = bank_q[b];
    end
  end

endmodule

// File: tb/tb_ram_sdp_fifo.sv
// Self-checking bench: two FIFO configurations checked every cycle against a
// count/head array model, plus directed scenarios with literal expectations.
module tb_ram_sdp_fifo;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Instance A: WIDTH=6, DEPTH_LOG2=5, AFULL_THRESH=28
  logic       fl_a = 0, iv_a = 0, or_a = 0;
  logic [5:0] id_a = '0;
  logic       ir_a, ov_a, af_a, of_a;
  logic [5:0] od_a, used_a;

  // Instance B: WIDTH=16, DEPTH_LOG2=7, AFULL_THRESH=100
  logic        fl_b = 0, iv_b = 0, or_b = 0;
  logic [15:0] id_b = '0;
  logic        ir_b, ov_b, af_b, of_b;
  logic [15:0] od_b;
  logic [7:0]  used_b;

  ram_sdp_fifo #(.WIDTH(6), .DEPTH_LOG2(5), .AFULL_THRESH(28)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(fl_a), .in_valid(iv_a), .in_ready(ir_a),
    .in_data(id_a), .out_valid(ov_a), .out_ready(or_a), .out_data(od_a),
    .used(used_a), .afull(af_a), .overflow(of_a));

  ram_sdp_fifo #(.WIDTH(16), .DEPTH_LOG2(7), .AFULL_THRESH(100)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(fl_b), .in_valid(iv_b), .in_ready(ir_b),
    .in_data(id_b), .out_valid(ov_b), .out_ready(or_b), .out_data(od_b),
    .used(used_b), .afull(af_b), .overflow(of_b));

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy count, head index and a circular word store per instance.
  int mdata [2][256];
  int mhead [2] = '{0, 0};
  int mcnt  [2] = '{0, 0};
  bit movf  [2] = '{0, 0};

  function automatic int dep_of(input int u);
    return (u == 0) ? 32 : 128;
  endfunction

  function automatic int thr_of(input int u);
    return (u == 0) ? 28 : 100;
  endfunction

  task automatic model_step(input int u, input bit v, input int d, input bit r, input bit f);
    int dep, c, h;
    dep = dep_of(u);
    c   = mcnt[u];
    h   = mhead[u];
    if (f) begin
      mcnt[u]  <= 0;
      mhead[u] <= 0;
      movf[u]  <= 1'b0;
    end else begin
      if (v && c == dep) movf[u] <= 1'b1;
      if (r && c > 0) begin
        h = (h + 1) % dep;
        c = c - 1;
      end
      if (v && mcnt[u] < dep) begin
        mdata[u][(h + c) % dep] <= d;
        c = c + 1;
      end
      mcnt[u]  <= c;
      mhead[u] <= h;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int u = 0; u < 2; u++) begin
        mcnt[u]  <= 0;
        mhead[u] <= 0;
        movf[u]  <= 1'b0;
      end
    end else begin
      model_step(0, iv_a, int'(id_a), or_a, fl_a);
      model_step(1, iv_b, int'(id_b), or_b, fl_b);
    end
  end

  task automatic cmp(input int u, input bit ir, input bit ov, input bit af, input bit of,
                     input int od, input int used);
    check($sformatf("u%0d used", u),      used, mcnt[u]);
    check($sformatf("u%0d in_ready", u),  int'(ir), int'(mcnt[u] < dep_of(u)));
    check($sformatf("u%0d out_valid", u), int'(ov), int'(mcnt[u] > 0));
    check($sformatf("u%0d afull", u),     int'(af), int'(mcnt[u] >= thr_of(u)));
    check($sformatf("u%0d overflow", u),  int'(of), int'(movf[u]));
    if (mcnt[u] > 0) check($sformatf("u%0d out_data", u), od, mdata[u][mhead[u]]);
  endtask

  always @(negedge clk) begin
    cmp(0, ir_a, ov_a, af_a, of_a, int'(od_a), int'(used_a));
    cmp(1, ir_b, ov_b, af_b, of_b, int'(od_b), int'(used_b));
  end

  task automatic step_a(input bit v, input int d, input bit r, input bit f);
    iv_a = v; id_a = 6'(d); or_a = r; fl_a = f;
    @(posedge clk);
    @(negedge clk);
    iv_a = 0; or_a = 0; fl_a = 0;
  endtask

  task automatic step_b(input bit v, input int d, input bit r, input bit f);
    iv_b = v; id_b = 16'(d); or_b = r; fl_b = f;
    @(posedge clk);
    @(negedge clk);
    iv_b = 0; or_b = 0; fl_b = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset used",      int'(used_a), 0);
    check("reset in_ready",  int'(ir_a),   1);
    check("reset out_valid", int'(ov_a),   0);
    check("reset afull",     int'(af_a),   0);
    check("reset overflow",  int'(of_a),   0);

    // Push 1..5 without popping, then drain in order.
    for (int i = 1; i <= 5; i++) step_a(1, i, 0, 0);
    check("t1 used",      int'(used_a), 5);
    check("t1 out_valid", int'(ov_a),   1);
    check("t1 head",      int'(od_a),   1);
    for (int i = 1; i <= 5; i++) begin
      check("t1 drain data", int'(od_a), i);
      step_a(0, 0, 1, 0);
    end
    check("t1 used end",      int'(used_a), 0);
    check("t1 out_valid end", int'(ov_a),   0);

    // Fill to 32, watch afull rise at 28, then overflow on a 33rd push.
    for (int i = 0; i < 32; i++) begin
      step_a(1, i, 0, 0);
      check("t2 afull", int'(af_a), int'(i + 1 >= 28));
    end
    check("t2 in_ready full", int'(ir_a), 0);
    step_a(1, 6'h3F, 0, 0);
    check("t2 overflow",   int'(of_a),   1);
    check("t2 used stays", int'(used_a), 32);
    for (int i = 0; i < 32; i++) begin
      check("t2 drain data", int'(od_a), i);
      step_a(0, 0, 1, 0);
    end
    check("t2 used end",       int'(used_a), 0);
    check("t2 overflow sticky", int'(of_a),  1);

    // Streaming push+pop of 100 words; pointers wrap several times.
    for (int i = 0; i < 100; i++) begin
      if (i > 0) check("t3 stream data", int'(od_a), (i - 1) & 63);
      step_a(1, i & 63, 1, 0);
      check("t3 used", int'(used_a), 1);
    end
    check("t3 last data", int'(od_a), 99 & 63);
    step_a(0, 0, 1, 0);
    check("t3 used end", int'(used_a), 0);

    // Full with overflow, then flush together with push and pop.
    for (int i = 0; i < 32; i++) step_a(1, (i + 7) & 63, 0, 0);
    step_a(1, 6'h3F, 0, 0);
    check("t5 overflow before", int'(of_a), 1);
    step_a(1, 6'h2A, 1, 1);
    check("t5 used",      int'(used_a), 0);
    check("t5 overflow",  int'(of_a),   0);
    check("t5 out_valid", int'(ov_a),   0);
    check("t5 afull",     int'(af_a),   0);
    step_a(1, 6'h15, 0, 0);
    check("t5 no stale word", int'(od_a),   6'h15);
    check("t5 used one",      int'(used_a), 1);
    step_a(0, 0, 1, 0);

    // Asynchronous reset in the middle of a burst.
    for (int i = 1; i <= 9; i++) step_a(1, i, 0, 0);
    iv_a = 1; id_a = 6'd10;
    @(posedge clk);
    #2;
    check("t6 used before reset", int'(used_a), 10);
    rst_n = 1'b0;
    #1;
    check("t6 async used",      int'(used_a), 0);
    check("t6 async out_valid", int'(ov_a),   0);
    check("t6 async in_ready",  int'(ir_a),   1);
    check("t6 async afull",     int'(af_a),   0);
    iv_a = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step_a(1, 6'h33, 0, 0);
    check("t6 resume data", int'(od_a),   6'h33);
    check("t6 resume used", int'(used_a), 1);
    step_a(0, 0, 1, 0);

    // Wide/deep instance: fill all 4 banks, overflow once, drain.
    for (int i = 0; i < 128; i++) step_b(1, i * 16'h0101, 0, 0);
    check("t4 used full", int'(used_b), 128);
    check("t4 in_ready",  int'(ir_b),   0);
    check("t4 afull",     int'(af_b),   1);
    step_b(1, 16'hBEEF, 0, 0);
    check("t4 overflow",  int'(of_b),   1);
    for (int i = 0; i < 128; i++) begin
      check("t4 drain data", int'(od_b), i * 16'h0101);
      step_b(0, 0, 1, 0);
    end
    check("t4 used end",      int'(used_b), 0);
    check("t4 out_valid end", int'(ov_b),   0);

    // Randomised traffic on both instances; the per-cycle compare does the checking.
    for (int n = 0; n < 3000; n++) begin
      iv_a = ($urandom % 4) != 0;
      id_a = 6'($urandom);
      or_a = ($urandom % 2) != 0;
      fl_a = ($urandom % 128) == 0;
      iv_b = ($urandom % 3) != 0;
      id_b = 16'($urandom);
      or_b = ($urandom % 3) != 0;
      fl_b = ($urandom % 256) == 0;
      @(posedge clk);
      @(negedge clk);
    end
    iv_a = 0; or_a = 0; fl_a = 0;
    iv_b = 0; or_b = 0; fl_b = 0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
